// File: rtl/mux_key_lookup_pkg.sv
// Shared helpers for the key-to-data lookup multiplexer: index width
// computation and pair slice offsets inside the packed table.
package mux_key_lookup_pkg;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int p = 1; p < value; p = p * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Width of a pair index; never narrower than one bit.
    function automatic int idx_width(input int nr_key);
        int w;
        w = clog2(nr_key);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

    // Bit offset of the data field (the LSB) of pair i.
    function automatic int pair_data_lsb(input int i, input int key_len, input int data_len);
        return i * (key_len + data_len);
    endfunction

    // Bit offset of the key field of pair i; the key sits above the data.
    function automatic int pair_key_lsb(input int i, input int key_len, input int data_len);
        return (i * (key_len + data_len)) + data_len;
    endfunction

endpackage

// File: rtl/mux_key_lookup_if.sv
// Lookup bus: table, probe key and default in; combinational and registered
// results out. The client drives through master, the lookup block is slave.
interface mux_key_lookup_if
    import mux_key_lookup_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
);
    localparam int IDX_W = idx_width(NR_KEY);
    localparam int LUT_W = NR_KEY * (KEY_LEN + DATA_LEN);

    logic [KEY_LEN-1:0]  key;
    logic [DATA_LEN-1:0] default_out;
    logic [LUT_W-1:0]    lut;
    logic                en;
    logic [DATA_LEN-1:0] out;
    logic                hit;
    logic [IDX_W-1:0]    hit_idx;
    logic [DATA_LEN-1:0] out_q;
    logic                hit_q;

    modport master (
        output key, default_out, lut, en,
        input  out, hit, hit_idx, out_q, hit_q
    );

    modport slave (
        input  key, default_out, lut, en,
        output out, hit, hit_idx, out_q, hit_q
    );
endinterface

// File: rtl/mux_key_match.sv
// Key comparator bank plus highest-index priority encoder. The highest
// matching index wins so that the first-written pair of a concatenated
// table takes precedence on duplicate keys.
module mux_key_match
    import mux_key_lookup_pkg::*;
#(
    parameter int NR_KEY  = 2,
    parameter int KEY_LEN = 1
) (
    input  logic [KEY_LEN-1:0]        key,
    input  logic [NR_KEY*KEY_LEN-1:0] keys,
    output logic                      hit,
    output logic [idx_width(NR_KEY)-1:0] hit_idx
);
    localparam int IDX_W = idx_width(NR_KEY);

    logic [NR_KEY-1:0] match_s;
    logic              hit_s;
    logic [IDX_W-1:0]  hit_idx_s;

    // Exact compare of every pair key against the probe key.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            match_s[i] = (keys[i*KEY_LEN +: KEY_LEN] == key);
        end
    end

    // Priority encode: scanning upwards, a later (higher) match overrides.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (match_s[i]) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    assign hit     = hit_s;
    assign hit_idx = hit_idx_s;

endmodule

// File: rtl/mux_key_lookup.sv
// Parameterised key-to-data lookup with default. The combinational result
// is the primary output; out_q/hit_q give a one-cycle registered copy.
module mux_key_lookup
    import mux_key_lookup_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_key_lookup_if.slave bus
);
    localparam int IDX_W = idx_width(NR_KEY);

    logic [NR_KEY*KEY_LEN-1:0] keys_s;
    logic [DATA_LEN-1:0]       data_s [NR_KEY];
    logic                      hit_s;
    logic [IDX_W-1:0]          hit_idx_s;
    logic [DATA_LEN-1:0]       out_s;

    logic [DATA_LEN-1:0]       out_d;
    logic [DATA_LEN-1:0]       out_q;
    logic                      hit_d;
    logic                      hit_q;

    // Split the packed table into a flat key vector and a data array.
    always_comb begin
        keys_s = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            keys_s[i*KEY_LEN +: KEY_LEN] = bus.lut[pair_key_lsb(i, KEY_LEN, DATA_LEN) +: KEY_LEN];
            data_s[i] = bus.lut[pair_data_lsb(i, KEY_LEN, DATA_LEN) +: DATA_LEN];
        end
    end

    mux_key_match #(
        .NR_KEY  (NR_KEY),
        .KEY_LEN (KEY_LEN)
    ) u_match (
        .key     (bus.key),
        .keys    (keys_s),
        .hit     (hit_s),
        .hit_idx (hit_idx_s)
    );

    // Select the winning pair's data, or the default when nothing matched.
    always_comb begin
        out_s = bus.default_out;
        if (hit_s) begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (hit_idx_s == IDX_W'(i)) begin
                    out_s = data_s[i];
                end else begin
                    out_s = out_s;
                end
            end
        end else begin
            out_s = bus.default_out;
        end
    end

    // Next state of the registered copy: load on en, otherwise hold.
    always_comb begin
        out_d = out_q;
        hit_d = hit_q;
        if (bus.en) begin
            out_d = out_s;
            hit_d = hit_s;
        end else begin
            out_d = out_q;
            hit_d = hit_q;
        end
    end

    // Registered outputs with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            hit_q <= 1'b0;
        end else begin
            out_q <= out_d;
            hit_q <= hit_d;
        end
    end

    assign bus.out     = out_s;
    assign bus.hit     = hit_s;
    assign bus.hit_idx = hit_idx_s;
    assign bus.out_q   = out_q;
    assign bus.hit_q   = hit_q;

endmodule

// File: tb/tb_mux_key_lookup.sv
// Bench for mux_key_lookup: directed decoder-table cases, duplicate keys,
// registered path, async reset, NR_KEY=1 boundary and randomized tables
// checked against a table-scan reference model.
module tb_mux_key_lookup;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Decoder configuration and single-entry configuration.
    mux_key_lookup_if #(.NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32)) bus8 ();
    mux_key_lookup_if #(.NR_KEY(1), .KEY_LEN(3), .DATA_LEN(4))  bus1 ();

    mux_key_lookup #(.NR_KEY(8), .KEY_LEN(7), .DATA_LEN(32)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    mux_key_lookup #(.NR_KEY(1), .KEY_LEN(3), .DATA_LEN(4)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table for the 8-entry DUT, indexed by pair index.
    logic [6:0]  tk [8];
    logic [31:0] td [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Put the reference table onto the bus: pair i occupies bits [i*39 +: 39].
    task automatic load8();
        for (int i = 0; i < 8; i++) begin
            bus8.lut[i*39 +: 39] = {tk[i], td[i]};
        end
    endtask

    // Reference lookup: first-written pair is the highest index, so scan
    // from the top down and take the first equal key.
    task automatic ref8(input logic [6:0] k, input logic [31:0] dflt,
                        output logic [31:0] o, output logic h, output logic [2:0] idx);
        o   = dflt;
        h   = 1'b0;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!h && tk[i] == k) begin
                o   = td[i];
                h   = 1'b1;
                idx = 3'(i);
            end
        end
    endtask

    logic [31:0] exp_o;
    logic        exp_h;
    logic [2:0]  exp_i;
    logic [31:0] exp_oq;
    logic        exp_hq;
    logic        e;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus8.en = 1'b0;
        bus8.key = 7'd0;
        bus8.default_out = 32'd0;
        bus8.lut = '0;
        bus1.en = 1'b0;
        bus1.key = 3'd0;
        bus1.default_out = 4'd0;
        bus1.lut = 7'd0;

        // Reset state.
        #2;
        check("rst_out_q", bus8.out_q, 64'd0);
        check("rst_hit_q", bus8.hit_q, 64'd0);
        check("rst1_out_q", bus1.out_q, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Decoder table, index 7 is first written.
        tk[7] = 7'b0010111; td[7] = 32'hAAAA_A000;
        tk[6] = 7'b0110111; td[6] = 32'h1234_5000;
        tk[5] = 7'b0010011; td[5] = 32'hFFFF_FFFF;
        tk[4] = 7'b0000011; td[4] = 32'h0000_0004;
        tk[3] = 7'b0100011; td[3] = 32'h0000_0003;
        tk[2] = 7'b1100011; td[2] = 32'h0000_0002;
        tk[1] = 7'b1101111; td[1] = 32'h0000_0001;
        tk[0] = 7'b1100111; td[0] = 32'h0000_0000;
        load8();

        bus8.key = 7'b0110111;
        #1;
        check("lui_out", bus8.out, 64'h1234_5000);
        check("lui_hit", bus8.hit, 64'd1);
        check("lui_idx", bus8.hit_idx, 64'd6);
        bus8.key = 7'b0010111;
        #1;
        check("auipc_out", bus8.out, 64'hAAAA_A000);
        check("auipc_idx", bus8.hit_idx, 64'd7);
        bus8.key = 7'b0110011;
        bus8.default_out = 32'd0;
        #1;
        check("miss_out", bus8.out, 64'd0);
        check("miss_hit", bus8.hit, 64'd0);
        check("miss_idx", bus8.hit_idx, 64'd0);
        bus8.default_out = 32'hDEAD_BEEF;
        #1;
        check("miss_dflt", bus8.out, 64'hDEAD_BEEF);

        // Registered path: hit, then miss, then hold.
        @(negedge clk);
        bus8.en  = 1'b1;
        bus8.key = 7'b0110111;
        @(posedge clk); #1;
        check("reg_hit_q", bus8.out_q, 64'h1234_5000);
        check("reg_hit_hq", bus8.hit_q, 64'd1);
        @(negedge clk);
        bus8.key = 7'b0110011;
        @(posedge clk); #1;
        check("reg_miss_q", bus8.out_q, 64'hDEAD_BEEF);
        check("reg_miss_hq", bus8.hit_q, 64'd0);
        @(negedge clk);
        bus8.en  = 1'b0;
        bus8.key = 7'b0110111;
        @(posedge clk); #1;
        check("hold_q", bus8.out_q, 64'hDEAD_BEEF);
        check("hold_hq", bus8.hit_q, 64'd0);

        // Async reset between edges.
        @(negedge clk);
        bus8.en = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_q", bus8.out_q, 64'h1234_5000);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", bus8.out_q, 64'd0);
        check("arst_hq", bus8.hit_q, 64'd0);
        check("arst_out", bus8.out, 64'h1234_5000);
        @(posedge clk); #1;
        check("in_rst_q", bus8.out_q, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_q", bus8.out_q, 64'h1234_5000);
        check("rel_hq", bus8.hit_q, 64'd1);

        // Duplicate keys on pairs 3 and 5.
        for (int i = 0; i < 8; i++) begin
            tk[i] = 7'(i + 1);
            td[i] = 32'(8'hA0 + i);
        end
        tk[3] = 7'h55; td[3] = 32'h11;
        tk[5] = 7'h55; td[5] = 32'h22;
        load8();
        bus8.key = 7'h55;
        #1;
        check("dup_out", bus8.out, 64'h22);
        check("dup_idx", bus8.hit_idx, 64'd5);
        check("dup_hit", bus8.hit, 64'd1);

        // Single-entry boundary.
        bus1.lut = {3'b101, 4'h9};
        bus1.default_out = 4'h6;
        bus1.key = 3'b101;
        #1;
        check("n1_out", bus1.out, 64'h9);
        check("n1_hit", bus1.hit, 64'd1);
        check("n1_idx", bus1.hit_idx, 64'd0);
        bus1.key = 3'b100;
        #1;
        check("n1_miss_out", bus1.out, 64'h6);
        check("n1_miss_hit", bus1.hit, 64'd0);
        check("n1_miss_idx", bus1.hit_idx, 64'd0);

        // Randomized tables with a small key space so duplicates and hits are common.
        exp_oq = bus8.out_q;
        exp_hq = bus8.hit_q;
        @(negedge clk);
        exp_oq = 32'h1234_5000;
        exp_hq = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 8; i++) begin
                tk[i] = 7'($urandom_range(0, 7));
                td[i] = $urandom;
            end
            load8();
            bus8.key = 7'($urandom_range(0, 8));
            bus8.default_out = $urandom;
            e = 1'($urandom_range(0, 1));
            bus8.en = e;
            ref8(bus8.key, bus8.default_out, exp_o, exp_h, exp_i);
            #1;
            check("rnd_out", bus8.out, 64'(exp_o));
            check("rnd_hit", bus8.hit, 64'(exp_h));
            check("rnd_idx", bus8.hit_idx, 64'(exp_i));
            if (e) begin
                exp_oq = exp_o;
                exp_hq = exp_h;
            end
            @(posedge clk); #1;
            check("rnd_out_q", bus8.out_q, 64'(exp_oq));
            check("rnd_hit_q", bus8.hit_q, 64'(exp_hq));
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_key_lookup.md
Name: mux_key_lookup

Overview:
- Parameterised key-to-data lookup multiplexer with default.
- A packed table of NR_KEY {key, data} pairs is compared against an input key. Output is the data of the matching pair, or default_out when nothing matches.
- Used by the decoder to select immediates by opcode. The combinational path is the primary output; a registered copy (1-cycle latency) is also provided for pipelined users.

Parameters:
- NR_KEY, 2, number of {key, data} pairs in the table (must be at least 1).
- KEY_LEN, 1, width of each key in bits.
- DATA_LEN, 1, width of each data word and of the outputs in bits.
- IDX_W, derived as max(1, clog2(NR_KEY)), width of hit_idx (localparam, not overridable).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- key  in  KEY_LEN  lookup key.
- default_out  in  DATA_LEN  value driven when no key matches.
- lut  in  NR_KEY*(KEY_LEN+DATA_LEN)  packed table.
- en  in  1  load enable for the registered outputs.
- out  out  DATA_LEN  combinational lookup result.
- hit  out  1  combinational; 1 when at least one pair key equals key.
- hit_idx  out  IDX_W  combinational index of the selected pair; 0 when hit=0.
- out_q  out  DATA_LEN  registered out.
- hit_q  out  1  registered hit.

Behaviour:
- Table packing: pair i occupies lut[(i+1)*W-1 : i*W], where W = KEY_LEN+DATA_LEN.
  - The pair key is the upper KEY_LEN bits of the slice; data is the lower DATA_LEN bits.
  - In a concatenation {k_A, d_A, k_B, d_B, ...}, the first-written pair therefore has index NR_KEY-1.
- Match: match[i] = (pair key i == key), exact compare of all KEY_LEN bits.
- Selection:
  - If any match[i] is set, out = data of the highest-index matching pair (first-written pair wins on duplicate keys) and hit_idx = that i.
  - If no pair matches, out = default_out, hit = 0, hit_idx = 0.
- Combinational outputs (out, hit, hit_idx):
  - Zero latency, purely combinational.
  - Independent of clk, rst_n and en.
  - No latches; every path fully assigned.
- Registered outputs:
  - On rising clk with en=1: out_q <= out, hit_q <= hit.
  - With en=0: out_q and hit_q hold their values.
- Reset:
  - rst_n=0 asynchronously forces out_q = 0 and hit_q = 0, regardless of clk and en.
  - Release is synchronous to the next clk edge; the first load after release follows the en rule.
  - Reset asserted mid-operation clears the registers immediately; combinational outputs keep tracking the inputs.
- X-safety: if key or lut contain X/Z, out may be X. No assertion is required; simulation displays nothing.
- NR_KEY=1 boundary: IDX_W = 1, and hit_idx is always 0.

Decomposition:
- Shared package: function clog2, and a macro or function computing slice offsets from (i, KEY_LEN, DATA_LEN).
- One natural sub-module, mux_key_match:
  - Generates the NR_KEY-bit match vector plus a highest-index priority encoder (hit, hit_idx).
  - The top level then indexes the data slice and registers the outputs.

Test Plan:
- Decoder configuration NR_KEY=8, KEY_LEN=7, DATA_LEN=32, with the table first-written {0010111, 0xAAAA_A000; 0110111, 0x1234_5000; 0010011, 0xFFFF_FFFF; ...}.
  - key=0110111 -> out=0x1234_5000, hit=1, hit_idx=6.
  - key=0010111 -> out=0xAAAA_A000, hit_idx=7.
- Same table, key=0110011 (not present), default_out=0 -> out=0, hit=0, hit_idx=0.
  - Then default_out=0xDEAD_BEEF -> out=0xDEAD_BEEF combinationally.
- Duplicate keys: pairs 3 and 5 both use key 0x55, with data 0x11 and 0x22.
  - key=0x55 -> out=0x22, hit_idx=5.
- Registered path:
  - en=1, key switched from a hit (data 0x1234_5000) to a miss: out_q shows 0x1234_5000 one edge later, then the default value the following edge.
  - en=0 -> out_q and hit_q hold their values.
- Async reset:
  - Assert rst_n=0 between clock edges while out_q=0x1234_5000 -> out_q=0 and hit_q=0 immediately, while out still equals 0x1234_5000.
  - Deassert -> out_q reloads on the next edge with en=1.
- NR_KEY=1, KEY_LEN=3, DATA_LEN=4, table {3'b101, 4'h9}:
  - key=101 -> out=9, hit=1.
  - key=100 -> out=default_out, hit=0.
